// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_pkg
//  Brief    : Shared widths, types and constants for the accumulator register
//             file and its load scoreboard.
//  Revision : 1.0
// ============================================================================
package rf_pkg;

    localparam int RF_W    = 8;     // default data width
    localparam int RF_D    = 4;     // default address width (2**RF_D registers)
    localparam int ACC_IDX = 0;     // default accumulator register index

    typedef logic [RF_D-1:0] addr_t;
    typedef logic [RF_W-1:0] word_t;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/reg_file_acc_sb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Brief    : One pending bit per register tracking outstanding loads, and
//             the decode stall derived from live reads of pending registers.
//  Revision : 1.0
// ============================================================================
module reg_scoreboard #(
    parameter int          D      = 4,
    parameter int unsigned ACC    = 0,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_ld_issue,
    input  logic [D-1:0] i_ld_addr,
    input  logic         i_we1,
    input  logic [D-1:0] i_waddr1,
    input  logic         i_ren_b,
    input  logic [D-1:0] i_raddr_b,
    input  logic         i_ren_c,
    input  logic [D-1:0] i_raddr_c,
    output logic         o_stall
);

    localparam int           c_NREG     = 2**D;
    localparam logic [D-1:0] c_ACC_ADDR = ACC[D-1:0];

    logic [c_NREG-1:0] r_pending;
    logic [c_NREG-1:0] w_pending_nxt;
    logic              w_fwd_b;
    logic              w_fwd_c;
    logic              w_fwd_acc;

    // Next pending vector: load return clears, a new issue sets and wins on collision
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_we1) begin
            w_pending_nxt[i_waddr1] = 1'b0;
        end
        if (i_ld_issue) begin
            w_pending_nxt[i_ld_addr] = 1'b1;
        end
    end

    // Pending state, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // A load returning this cycle is forwarded to the reader, so it need not wait
    assign w_fwd_b   = BYPASS && i_we1 && (i_waddr1 == i_raddr_b);
    assign w_fwd_c   = BYPASS && i_we1 && (i_waddr1 == i_raddr_c);
    assign w_fwd_acc = BYPASS && i_we1 && (i_waddr1 == c_ACC_ADDR);

    // Accumulator is always read, so its pending bit stalls unconditionally
    assign o_stall = (i_ren_b && r_pending[i_raddr_b] && !w_fwd_b)
                   | (i_ren_c && r_pending[i_raddr_c] && !w_fwd_c)
                   | (r_pending[c_ACC_ADDR] && !w_fwd_acc);

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file_acc_sb.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file_acc_sb
//  Brief    : Accumulator-style register file with two write ports (ALU,
//             load return), two general read ports plus the fixed ACC port,
//             optional write-to-read bypass and a load scoreboard stall.
//  Revision : 1.0
// ============================================================================
module reg_file_acc_sb
    import rf_pkg::*;
#(
    parameter int          W      = RF_W,
    parameter int          D      = RF_D,
    parameter int unsigned ACC    = ACC_IDX,
    parameter bit          BYPASS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we0,
    input  logic [D-1:0] waddr0,
    input  logic [W-1:0] wdata0,
    input  logic         we1,
    input  logic [D-1:0] waddr1,
    input  logic [W-1:0] wdata1,
    input  logic         ld_issue,
    input  logic [D-1:0] ld_addr,
    input  logic         ren_b,
    input  logic [D-1:0] raddrB,
    input  logic         ren_c,
    input  logic [D-1:0] raddrC,
    output logic [W-1:0] data_outA,
    output logic [W-1:0] data_outB,
    output logic [W-1:0] data_outC,
    output logic         acc_zero,
    output logic         stall
);

    localparam int           c_NREG     = 2**D;
    localparam logic [D-1:0] c_ACC_ADDR = ACC[D-1:0];

    logic [W-1:0]   r_mem [c_NREG];
    logic           w_port1_wr;
    logic [3*D-1:0] w_raddr_flat;

    // Port 0 wins a same-address collision; port 1 data is dropped
    assign w_port1_wr = we1 && !(we0 && (waddr0 == waddr1));

    // Storage array, cleared asynchronously on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_port1_wr) begin
                r_mem[waddr1] <= wdata1;
            end
            if (we0) begin
                r_mem[waddr0] <= wdata0;
            end
        end
    end

    // Read port addresses: slot 0 = ACC, slot 1 = B, slot 2 = C
    assign w_raddr_flat = {raddrC, raddrB, c_ACC_ADDR};

    for (genvar g = 0; g < 3; g++) begin : g_rd
        logic [D-1:0] w_addr;
        logic [W-1:0] w_data;

        assign w_addr = w_raddr_flat[g*D +: D];

        // Stored value, overridden by same-cycle write data when bypass is on
        always_comb begin
            w_data = r_mem[w_addr];
            if (BYPASS) begin
                if (we0 && (waddr0 == w_addr)) begin
                    w_data = wdata0;
                end else if (we1 && (waddr1 == w_addr)) begin
                    w_data = wdata1;
                end
            end
        end
    end

    assign data_outA = g_rd[0].w_data;
    assign data_outB = g_rd[1].w_data;
    assign data_outC = g_rd[2].w_data;

    // Zero flag follows the stored accumulator, never the forwarded value
    assign acc_zero = (r_mem[c_ACC_ADDR] == '0);

    reg_scoreboard #(
        .D      (D),
        .ACC    (ACC),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_ld_issue (ld_issue),
        .i_ld_addr  (ld_addr),
        .i_we1      (we1),
        .i_waddr1   (waddr1),
        .i_ren_b    (ren_b),
        .i_raddr_b  (raddrB),
        .i_ren_c    (ren_c),
        .i_raddr_c  (raddrC),
        .o_stall    (stall)
    );

endmodule : reg_file_acc_sb
`default_nettype wire
